// File: rtl/digit_serial_mult_ctrl.sv
// digit_serial_mult_ctrl
//   Computes a WIDTH x WIDTH unsigned product one 4-bit digit pair per cycle
//   through a single shared 4x4 multiplier (wallace_tree_4_bit), shift-
//   accumulating each 8-bit partial product into a 2*WIDTH accumulator.
//   Latency is fixed at NUM_DIGITS^2 cycles from accept to valid_out.
//
// Ports
//   clk_in        system clock
//   rst_in        synchronous active-high reset; aborts any operation
//   valid_in      request valid (only looked at in IDLE)
//   a_in, b_in    WIDTH-bit unsigned operands, latched on accept
//   ready_out     high in IDLE: a request is taken on valid_in && ready_out
//   product_out   2*WIDTH-bit result, held until the next result replaces it
//   valid_out     product_out is valid; held until out_ready_in is seen high
//   out_ready_in  consumer accepts the product
//   busy_out      high whenever the sequencer is not IDLE

// 4x4 unsigned multiplier: four partial-product rows reduced by two
// carry-save (3:2) stages, then one carry-propagate add. The product of two
// 4-bit values fits in 8 bits, so bits shifted past bit 7 are always zero
// in the final sum.
module wallace_tree_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [7:0] r0, r1, r2, r3;
  logic [7:0] s1, c1, s2, c2;

  always_comb begin
    r0 = {4'b0000, a & {4{b[0]}}};
    r1 = {3'b000,  a & {4{b[1]}}, 1'b0};
    r2 = {2'b00,   a & {4{b[2]}}, 2'b00};
    r3 = {1'b0,    a & {4{b[3]}}, 3'b000};
    s1 = r0 ^ r1 ^ r2;
    c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    s2 = s1 ^ c1 ^ r3;
    c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
    p  = s2 + c2;
  end
endmodule

module digit_serial_mult_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready_out,
  output logic [2*WIDTH-1:0] product_out,
  output logic               valid_out,
  input  logic               out_ready_in,
  output logic               busy_out
);
  localparam int NUM_DIGITS = WIDTH / 4;
  localparam int ACC_W      = 2 * WIDTH;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("digit_serial_mult_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [IDX_W-1:0] i_idx, j_idx;
  logic [3:0]       a_digit, b_digit;
  logic [7:0]       pp;
  logic [IDX_W+2:0] shamt;
  logic             accept, last_pair;

  assign ready_out = (state == IDLE);
  assign valid_out = (state == DONE);
  assign busy_out  = (state != IDLE);
  assign accept    = valid_in && ready_out;
  assign last_pair = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);

  // Digit selection and weighting: digit i of a and digit j of b carry a
  // combined weight of 2^(4*(i+j)).
  assign a_digit = 4'(a_reg >> {i_idx, 2'b00});
  assign b_digit = 4'(b_reg >> {j_idx, 2'b00});
  assign shamt   = {(IDX_W+1)'(i_idx) + (IDX_W+1)'(j_idx), 2'b00};
  assign acc_sum = acc + (ACC_W'(pp) << shamt);

  wallace_tree_4_bit u_mul (
    .a (a_digit),
    .b (b_digit),
    .p (pp)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (valid_in)     state_d = MULT;
      MULT:    if (last_pair)    state_d = DONE;
      DONE:    if (out_ready_in) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      i_idx       <= '0;
      j_idx       <= '0;
      product_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
          end
        end
        MULT: begin
          acc <= acc_sum;
          if (j_idx == LAST_IDX) begin
            j_idx <= '0;
            i_idx <= last_pair ? '0 : i_idx + 1'b1;
          end else begin
            j_idx <= j_idx + 1'b1;
          end
          // The final partial product lands in the result register on the
          // same edge that enters DONE, so it is stable for the whole DONE
          // phase and survives the next accept clearing acc.
          if (last_pair) product_out <= acc_sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Testbench for digit_serial_mult_ctrl: a WIDTH=16 instance carries the
// directed sequences and a random stream; a WIDTH=8 instance runs its own
// random stream alongside. Requests observed on the input handshake push
// a*b into a queue; a monitor pops and compares on each output handshake.
module tb_digit_serial_mult_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in;
  logic        valid_in, ready_out, valid_out, busy_out;
  logic [15:0] a_in, b_in;
  logic [31:0] product_out;
  logic        valid8_in, ready8_out, valid8_out, busy8_out;
  logic [7:0]  a8_in, b8_in;
  logic [15:0] product8_out;
  logic        or_force, rnd_phase, rnd_ready, out_ready_in;

  assign out_ready_in = rnd_phase ? rnd_ready : or_force;

  digit_serial_mult_ctrl #(.WIDTH(16)) dut16 (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
    .ready_out(ready_out), .product_out(product_out), .valid_out(valid_out),
    .out_ready_in(out_ready_in), .busy_out(busy_out)
  );

  digit_serial_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid8_in), .a_in(a8_in), .b_in(b8_in),
    .ready_out(ready8_out), .product_out(product8_out), .valid_out(valid8_out),
    .out_ready_in(out_ready_in), .busy_out(busy8_out)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp8_q[$];
  logic        stall16 = 1'b0, stall8 = 1'b0;
  logic [31:0] held16;
  logic [15:0] held8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard monitor: everything is sampled at the falling edge, i.e. the
  // values the DUT will see at the next rising edge.
  always @(negedge clk) begin
    if (rst_in) begin
      exp_q.delete();
      exp8_q.delete();
      stall16 = 1'b0;
      stall8  = 1'b0;
    end else begin
      check("busy_vs_ready16", busy_out, !ready_out);
      if (stall16) begin
        check("stall_valid16", valid_out, 1'b1);
        check("stall_hold16", product_out, held16);
      end
      if (valid_out) begin
        check("ready_in_done16", ready_out, 1'b0);
        if (out_ready_in) begin
          check("pending16", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("product16", product_out, exp_q.pop_front());
        end
      end
      if (valid_in && ready_out) exp_q.push_back(32'(a_in) * 32'(b_in));
      stall16 = valid_out && !out_ready_in;
      held16  = product_out;

      if (stall8) begin
        check("stall_valid8", valid8_out, 1'b1);
        check("stall_hold8", product8_out, held8);
      end
      if (valid8_out) begin
        check("ready_in_done8", ready8_out, 1'b0);
        if (out_ready_in) begin
          check("pending8", 64'(exp8_q.size() != 0), 1);
          if (exp8_q.size() != 0) check("product8", product8_out, exp8_q.pop_front());
        end
      end
      if (valid8_in && ready8_out) exp8_q.push_back(32'(16'(a8_in) * 16'(b8_in)));
      stall8 = valid8_out && !out_ready_in;
      held8  = product8_out;
    end
  end

  // Present a request on the WIDTH=16 port and hold it until accepted.
  // Returns just after the accepting edge with valid_in low and the operand
  // pins scrambled, so any use of them after acceptance would show up.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    @(posedge clk); #1;
    valid_in = 1'b1; a_in = a; b_in = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready_out && n < 1000);
    check("accept16", ready_out, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    valid8_in = 1'b1; a8_in = a; b8_in = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!ready8_out && n < 1000);
    check("accept8", ready8_out, 1'b1);
    @(posedge clk); #1;
    valid8_in = 1'b0; a8_in = 8'($urandom); b8_in = 8'($urandom);
  endtask

  // Called right after the accepting edge. lat = edges from accept until
  // valid_out is seen; busy_n = cycles with busy_out high. Stops when the
  // block is idle again or when a result is being held back by the consumer.
  task automatic wait_result(output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      if (busy_out) busy_n++;
      if (valid_out && lat < 0) lat = k - 1;
      if (!busy_out || (valid_out && !out_ready_in)) break;
    end
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand16(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(pick16(), pick16());
    end
  endtask

  task automatic rand8(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send8(8'(pick16()), 8'(pick16()));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, bsy, n;
    int          t_acc[3];
    logic [15:0] ta[3];
    logic [15:0] tb_ops[3];

    rst_in = 1'b1; valid_in = 1'b0; a_in = '0; b_in = '0;
    valid8_in = 1'b0; a8_in = '0; b8_in = '0;
    or_force = 1'b1; rnd_phase = 1'b0; rnd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;

    @(negedge clk);
    check("reset_ready", ready_out, 1'b1);
    check("reset_valid", valid_out, 1'b0);
    check("reset_busy", busy_out, 1'b0);
    check("reset_product", product_out, 32'h0);
    check("reset_product8", product8_out, 16'h0);

    // Full-scale operands: fixed latency and busy window.
    send(16'hFFFF, 16'hFFFF);
    wait_result(lat, bsy);
    check("lat_ffff", lat, 16);
    check("busy_ffff", bsy, 17);
    check("prod_ffff", product_out, 32'hFFFE0001);

    send(16'h1234, 16'h5678);
    wait_result(lat, bsy);
    check("lat_1234", lat, 16);
    check("prod_1234", product_out, 32'h06260060);

    send(16'h0000, 16'hABCD);
    wait_result(lat, bsy);
    check("lat_zero", lat, 16);
    check("prod_zero", product_out, 32'h0);

    // Backpressure: result held, new request ignored while DONE.
    or_force = 1'b0;
    send(16'h00FF, 16'h00FF);
    wait_result(lat, bsy);
    check("lat_bp", lat, 16);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin valid_in = 1'b1; a_in = 16'd3; b_in = 16'd3; end
      if (c == 3) valid_in = 1'b0;
      @(negedge clk);
      check("bp_valid", valid_out, 1'b1);
      check("bp_product", product_out, 32'h0000FE01);
      check("bp_ready", ready_out, 1'b0);
    end
    @(posedge clk); #1 or_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", ready_out, 1'b1);
    check("bp_release_valid", valid_out, 1'b0);
    check("idle_holds_product", product_out, 32'h0000FE01);
    send(16'd3, 16'd3);
    wait_result(lat, bsy);
    check("prod_3x3", product_out, 32'h9);

    // Reset sampled at the end of the 7th MULT cycle.
    send(16'hFFFF, 16'hFFFF);
    repeat (6) @(posedge clk);
    #1 rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    @(negedge clk);
    check("abort_ready", ready_out, 1'b1);
    check("abort_valid", valid_out, 1'b0);
    check("abort_busy", busy_out, 1'b0);
    check("abort_product", product_out, 32'h0);
    send(16'd2, 16'd3);
    wait_result(lat, bsy);
    check("lat_after_abort", lat, 16);
    check("prod_after_abort", product_out, 32'h6);

    // Throughput with valid_in held high and the consumer always ready.
    ta     = '{16'h0001, 16'h8000, 16'h00FF};
    tb_ops = '{16'h0001, 16'h0002, 16'h0100};
    @(posedge clk); #1;
    valid_in = 1'b1; a_in = ta[0]; b_in = tb_ops[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!ready_out && n < 100);
      check("tp_accept", ready_out, 1'b1);
      t_acc[k] = cyc;
      @(posedge clk); #1;
      if (k < 2) begin a_in = ta[k+1]; b_in = tb_ops[k+1]; end
      else valid_in = 1'b0;
    end
    wait_result(lat, bsy);
    check("tp_gap01", t_acc[1] - t_acc[0], 18);
    check("tp_gap12", t_acc[2] - t_acc[1], 18);
    check("tp_last_product", product_out, 32'h0000FF00);

    // Random streams on both widths with random consumer stalls.
    rnd_phase = 1'b1;
    fork
      rand16(1000);
      rand8(1000);
    join
    rnd_phase = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0 || busy_out || busy8_out) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain16", exp_q.size(), 0);
    check("drain8", exp8_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
